rom_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port synchronous ROM (16 x 4, registered read) between NREQ requesters. Each requester issues an address with a valid/ready handshake and receives a one-cycle response pulse carrying the ROM word. The block sits between the requesters and the rom instance and owns the ROM's en/addr inputs. Only one ROM access is in flight at a time.

---
 rtl/rom_rr_arbiter.sv | 90 +++++++++
 tb/tb_rom_rr_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rom_rr_arbiter.sv
// rom_rr_arbiter: round-robin arbiter sharing one registered-read ROM among NREQ requesters.
// One access in flight at a time: IDLE accepts, READ drives the ROM, CAPTURE registers the word.
module rom_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 4,
    parameter int DW   = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy,
    output logic                 rom_en,
    output logic [AW-1:0]        rom_addr,
    input  logic [DW-1:0]        rom_dout
);
    typedef enum logic [1:0] {IDLE, READ, CAPTURE} state_t;
    state_t state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d, gnt_q, gnt_d, rsp_id_q, rsp_id_d, g, idx;
    logic [AW-1:0] addr_q, addr_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic accept;
    // Scan offsets high to low so the candidate nearest rr_ptr is the last to win.
    always_comb begin
        g = '0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (req_valid[idx]) g = idx;
        end
    end
    assign accept    = rst && state_q == IDLE && |req_valid;
    assign req_ready = accept ? NREQ'(1) << g : '0;
    assign rom_en    = state_q == READ;
    assign rom_addr  = addr_q;
    assign busy      = state_q != IDLE;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        addr_d      = addr_q;
        gnt_d       = gnt_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            IDLE: if (accept) begin
                addr_d  = req_addr[g*AW +: AW];
                gnt_d   = g;
                state_d = READ;
            end
            READ: state_d = CAPTURE;
            CAPTURE: begin
                rsp_data_d  = rom_dout;
                rsp_id_d    = gnt_q;
                rsp_valid_d = NREQ'(1) << gnt_q;
                rr_ptr_d    = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            addr_q      <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            addr_q      <= addr_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end
endmodule

// File: tb/tb_rom_rr_arbiter.sv
// tb_rom_rr_arbiter: directed and random checks of rom_rr_arbiter against a transaction-level model.
module tb_rom_rr_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] req_valid, req_ready, rsp_valid, rsp_data, rom_addr, rom_dout;
    logic [15:0] req_addr;
    logic [1:0] rsp_id;
    logic busy, rom_en;
    int checks = 0;
    int errors = 0;
    // Model: cycle count, cycle at which the arbiter is free, one pending response.
    int cyc = 0, free_at = 0, ptr = 0, due = -1, pend_id = 0, last_addr = 0, last_id = 0;
    int pend_data = 0, last_data = 0;
    int ids[$];
    int datas[$];
    int exp_ids[6] = '{0, 1, 2, 3, 0, 1};
    int exp_datas[6] = '{15, 14, 13, 12, 15, 14};

    rom_rr_arbiter #(.NREQ(4), .AW(4), .DW(4), .IDW(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .busy(busy), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_dout(rom_dout)
    );

    always #5 clk = ~clk;
    always_ff @(posedge clk) if (rom_en) rom_dout <= 4'd15 - rom_addr;

    function automatic int pick(logic [3:0] v, int p);
        for (int k = 0; k < 4; k++) begin
            int i = (p + k) % 4;
            if (v[i[1:0]]) return i;
        end
        return -1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int g;
        logic [3:0] er, ev;
        #1;
        g = pick(req_valid, ptr);
        er = (rst && cyc >= free_at && g >= 0) ? 4'(1 << g) : 4'b0;
        ev = (due == cyc) ? 4'(1 << pend_id) : 4'b0;
        if (due == cyc) begin
            last_data = pend_data;
            last_id = pend_id;
        end
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rom_en", 32'(rom_en), 32'(cyc == free_at - 2));
        chk("rom_addr", 32'(rom_addr), 32'(last_addr));
        chk("busy", 32'(busy), 32'(cyc < free_at));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        chk("rsp_data", 32'(rsp_data), 32'(last_data));
        chk("rsp_id", 32'(rsp_id), 32'(last_id));
        if (rsp_valid !== 4'b0) begin
            ids.push_back(int'(rsp_id));
            datas.push_back(int'(rsp_data));
        end
    endtask

    task automatic tick();
        int g;
        g = pick(req_valid, ptr);
        if (!rst) begin
            free_at = cyc + 1;
            ptr = 0;
            due = -1;
            last_addr = 0;
            last_data = 0;
            last_id = 0;
        end else if (cyc >= free_at && g >= 0) begin
            free_at = cyc + 3;
            due = cyc + 3;
            pend_id = g;
            last_addr = int'(req_addr[g*4 +: 4]);
            pend_data = 15 - last_addr;
            ptr = (g + 1) % 4;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        check_all();
        tick();
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 4'hF;
        req_addr = 16'h3210;
        @(posedge clk);
        #1;
        repeat (2) step();
        // Round robin with all four requesting continuously.
        rst = 1'b1;
        ids.delete();
        datas.delete();
        check_all();
        chk("first_gnt", 32'(req_ready), 32'h1);
        tick();
        repeat (16) step();
        req_valid = 4'b0;
        repeat (3) step();
        chk("rr_count", 32'(ids.size()), 32'd6);
        for (int i = 0; i < 6 && i < ids.size(); i++) begin
            chk("rr_id", 32'(ids[i]), 32'(exp_ids[i]));
            chk("rr_data", 32'(datas[i]), 32'(exp_datas[i]));
        end
        // Single request from requester 2.
        req_valid = 4'b0100;
        req_addr = 16'h0300;
        check_all();
        chk("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0;
        check_all();
        chk("single_rom_en", 32'(rom_en), 32'h1);
        chk("single_rom_addr", 32'(rom_addr), 32'h3);
        tick();
        step();
        check_all();
        chk("single_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("single_rsp_data", 32'(rsp_data), 32'd12);
        chk("single_rsp_id", 32'(rsp_id), 32'd2);
        tick();
        // Pointer skip: serve 1, then 0 beats 1 when both request.
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0;
        repeat (2) step();
        req_valid = 4'b0011;
        check_all();
        chk("skip_gnt0", 32'(req_ready), 32'h1);
        tick();
        repeat (2) step();
        check_all();
        chk("skip_gnt1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0;
        repeat (3) step();
        // Reset during READ aborts the access.
        req_valid = 4'b1000;
        req_addr = 16'h5000;
        check_all();
        chk("abort_ready", 32'(req_ready), 32'h8);
        tick();
        rst = 1'b0;
        check_all();
        chk("abort_rom_addr", 32'(rom_addr), 32'h5);
        tick();
        rst = 1'b1;
        check_all();
        chk("abort_no_pulse", 32'(rsp_valid), 32'h0);
        chk("abort_regrant", 32'(req_ready), 32'h8);
        tick();
        repeat (2) step();
        check_all();
        chk("abort_rsp_valid", 32'(rsp_valid), 32'h8);
        chk("abort_rsp_data", 32'(rsp_data), 32'd10);
        chk("abort_rsp_id", 32'(rsp_id), 32'd3);
        tick();
        // Idle hold keeps the last response visible.
        req_valid = 4'b0;
        repeat (20) step();
        chk("hold_data", 32'(rsp_data), 32'd10);
        chk("hold_id", 32'(rsp_id), 32'd3);
        chk("hold_busy", 32'(busy), 32'h0);
        chk("hold_rom_en", 32'(rom_en), 32'h0);
        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            req_valid = 4'($urandom);
            req_addr = 16'($urandom);
            rst = ($urandom_range(0, 39) != 0);
            step();
        end
        rst = 1'b1;
        req_valid = 4'b0;
        repeat (4) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
